// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory for the MEM-stage load/store port.
// One access at a time; the pipeline is stalled for LATENCY cycles, then a
// one-cycle ack completes the access. Misaligned or out-of-range accesses
// complete with err_o set and leave memory untouched.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, data_q;
    logic        op_write_q, op_read_q, err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic             req;
    logic             accept;
    logic             complete;
    logic             bad;
    logic [IDX_W-1:0] idx;

    assign req      = mem_read_i | mem_write_i;
    assign accept   = (state_q == StIdle) & req;
    assign complete = (state_q == StBusy) & (cnt_q == 4'd1);
    assign bad      = (addr_q[1:0] != 2'b00) | (addr_q[31:2] >= DEPTH_LIM);
    assign idx      = addr_q[IDX_W+1:2];

    // Next-state and countdown logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cnt_d   = CNT_INIT;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            op_write_q <= 1'b0;
            op_read_q  <= 1'b0;
        end else if (accept) begin
            addr_q     <= addr_i;
            wdata_q    <= data_i;
            op_write_q <= mem_write_i;
            op_read_q  <= mem_read_i;
        end
    end

    // Load data and error flag update on the completion edge.
    // The read sees the pre-write contents when a store shares the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else if (complete) begin
            err_q <= bad;
            if (op_read_q) begin
                data_q <= bad ? 32'd0 : mem[idx];
            end
        end
    end

    // Unreset storage; a reset at the completion edge aborts the store.
    always_ff @(posedge clk_i) begin
        if (rst_i && complete && op_write_q && !bad) begin
            mem[idx] <= wdata_q;
        end
    end

    assign data_o  = data_q;
    assign ack_o   = (state_q == StDone);
    assign err_o   = (state_q == StDone) & err_q;
    assign stall_o = rst_i & (accept | (state_q == StBusy));

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table on a LATENCY=4 instance,
// hand-written reset sequences, and a scoreboard sweep on LATENCY=2 and 15.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [2:0]  stall;

    int errors = 0;
    int checks = 0;
    int lat_tab [3] = '{4, 2, 15};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut (
        .clk_i(clk), .rst_i(rst_n[0]), .mem_read_i(rd[0]), .mem_write_i(wr[0]),
        .addr_i(addr[0]), .data_i(wdata[0]), .data_o(rdata[0]), .ack_o(ack[0]),
        .err_o(err[0]), .stall_o(stall[0])
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst_n[1]), .mem_read_i(rd[1]), .mem_write_i(wr[1]),
        .addr_i(addr[1]), .data_i(wdata[1]), .data_o(rdata[1]), .ack_o(ack[1]),
        .err_o(err[1]), .stall_o(stall[1])
    );

    dmem_responder #(.DEPTH_WORDS(16), .LATENCY(15)) u_lat15 (
        .clk_i(clk), .rst_i(rst_n[2]), .mem_read_i(rd[2]), .mem_write_i(wr[2]),
        .addr_i(addr[2]), .data_i(wdata[2]), .data_o(rdata[2]), .ack_o(ack[2]),
        .err_o(err[2]), .stall_o(stall[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One access on instance k; observes cycles T .. T+lat+2.
    task automatic do_access(input int k, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd_data, output logic rd_err,
                             output int st_n, output int ack_n, output int ack_at);
        int lat;
        lat     = lat_tab[k];
        st_n    = 0;
        ack_n   = 0;
        ack_at  = -1;
        rd_data = 32'hxxxx_xxxx;
        rd_err  = 1'bx;
        @(posedge clk);
        #1;
        rd[k]    = r;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        for (int c = 0; c < lat + 3; c++) begin
            @(negedge clk);
            if (stall[k]) st_n++;
            if (ack[k]) begin
                ack_n++;
                if (ack_at < 0) begin
                    ack_at  = c;
                    rd_data = rdata[k];
                    rd_err  = err[k];
                end
            end
            if (c == 0) begin
                @(posedge clk);
                #1;
                rd[k]    = 1'b0;
                wr[k]    = 1'b0;
                addr[k]  = ~a;      // garbage while busy must be ignored
                wdata[k] = ~d;
            end
        end
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] sb [16];

    initial begin
        logic [31:0] got_d;
        logic        got_e;
        int          st_n, ack_n, ack_at, n;
        logic [31:0] wd;
        logic        r, w;
        int          ix;

        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got_d;
        logic        got_e;
        int          st_n, ack_n, ack_at, n;
        logic [31:0] wd;
        logic        r, w;
        int          ix;

        // data_o only changes on reads, so write rows expect the last read value.
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_1111, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_2222, 32'h0000_1111, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_2222, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_4040, 32'h0000_2222, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0000_2222, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0000_A5A5, 32'h0000_2222, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'h0000_A5A5, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,         32'h0000_0000, 1'b1};

        rst_n = 3'b000;
        rd    = 3'b001;   // request held during reset must not stall
        wr    = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr[k]  = 32'h0000_0001;
            wdata[k] = 32'h0;
        end

        // Reset with a pending request.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst ack", 32'(ack[0]), 32'h0);
        chk("rst err", 32'(err[0]), 32'h0);
        chk("rst data", rdata[0], 32'h0);
        chk("rst stall", 32'(stall[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 3'b111;
        @(negedge clk);
        chk("rst release stall", 32'(stall[0]), 32'h1);
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        n = 0;
        got_e = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack[0]) begin
                n++;
                got_e = err[0];
            end
        end
        chk("post-rst ack count", 32'(n), 32'h1);
        chk("post-rst misaligned err", 32'(got_e), 32'h1);
        chk("post-rst misaligned data", rdata[0], 32'h0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            do_access(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
                      got_d, got_e, st_n, ack_n, ack_at);
            chk($sformatf("vec%0d err", i), 32'(got_e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d data", i), got_d, vecs[i].exp_data);
            chk($sformatf("vec%0d stall cycles", i), 32'(st_n), 32'd4);
            chk($sformatf("vec%0d ack count", i), 32'(ack_n), 32'd1);
            chk($sformatf("vec%0d ack cycle", i), 32'(ack_at), 32'd4);
        end

        // Reset during BUSY aborts the store to 0x40.
        @(posedge clk);
        #1;
        wr[0] = 1'b1;
        addr[0] = 32'h0000_0040;
        wdata[0] = 32'h0000_5555;
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("midop stall in reset", 32'(stall[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack[0]) n++;
        end
        chk("midop no ack", 32'(n), 32'h0);
        do_access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, got_d, got_e, st_n, ack_n, ack_at);
        chk("midop prior contents", got_d, 32'h0000_4040);
        repeat (5) @(negedge clk);
        chk("data held idle", rdata[0], 32'h0000_4040);

        // Scoreboard sweep on LATENCY=2 and LATENCY=15.
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                do_access(k, 1'b0, 1'b1, 32'(i * 4), wd, got_d, got_e, st_n, ack_n, ack_at);
                sb[i] = wd;
                chk($sformatf("L%0d fill stall", lat_tab[k]), 32'(st_n), 32'(lat_tab[k]));
                chk($sformatf("L%0d fill ack", lat_tab[k]), 32'(ack_n), 32'd1);
            end
            for (int i = 0; i < 25; i++) begin
                r  = 1'($urandom_range(0, 1));
                w  = 1'($urandom_range(0, 1));
                if (!r && !w) r = 1'b1;
                ix = int'($urandom_range(0, 15));
                wd = $urandom;
                do_access(k, r, w, 32'(ix * 4), wd, got_d, got_e, st_n, ack_n, ack_at);
                chk($sformatf("L%0d op%0d stall", lat_tab[k], i), 32'(st_n), 32'(lat_tab[k]));
                chk($sformatf("L%0d op%0d ack count", lat_tab[k], i), 32'(ack_n), 32'd1);
                chk($sformatf("L%0d op%0d ack cycle", lat_tab[k], i), 32'(ack_at),
                    32'(lat_tab[k]));
                chk($sformatf("L%0d op%0d err", lat_tab[k], i), 32'(got_e), 32'h0);
                if (r) chk($sformatf("L%0d op%0d data", lat_tab[k], i), got_d, sb[ix]);
                if (w) sb[ix] = wd;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the CPU's MEM-stage load/store port. It replaces the single-cycle data memory behind the EX/MEM register. It accepts one word access at a time, holds the pipeline with a stall signal for a fixed, parameterised latency, then completes the access with a one-cycle acknowledge. Misaligned and out-of-range accesses complete with an error flag and no side effects.

## Interface
Parameters:
- DEPTH_WORDS, 256 — number of 32-bit words; legal byte addresses 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 4 — cycles from first request cycle to ack cycle; legal range 2..15.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- mem_read_i  in  1  load request; comes from EX/MEM MemRead.
- mem_write_i  in  1  store request; comes from EX/MEM MemWrite.
- addr_i  in  32  byte address; comes from EX/MEM ALU result.
- data_i  in  32  store data.
- data_o  out  32  load data; registered, held between reads.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  completion is an error; valid only while ack_o=1.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.

## Operation
- Request: req = mem_read_i | mem_write_i.
- Accepted request:
  - Latch addr_i, data_i, mem_write_i and mem_read_i.
  - Latched op_write = mem_write_i.
  - Latched op_read = mem_read_i.
  - Inputs are ignored until the next IDLE cycle.
- Error check uses latched values: bad = (addr[1:0] != 0) | (addr[31:2] >= DEPTH_WORDS).
- Word index = addr[31:2]. Storage is an unreset DEPTH_WORDS x 32 array.

State machine:
- IDLE:
  - req=0: stay in IDLE.
  - req=1: accept the request, load cnt = LATENCY-1, go to BUSY.
- BUSY:
  - cnt != 1: cnt <= cnt-1.
  - cnt == 1: perform the access and go to DONE.
    - Store and !bad: mem[idx] <= data.
    - Load and !bad: data_o <= mem[idx].
    - bad: no write; data_o <= 0 when op_read; err flag set.
- DONE: ack_o=1, err_o=flag, unconditionally go to IDLE.

Outputs and rules:
- stall_o = (IDLE & req) | BUSY. It is combinational from req, so the requesting cycle is already stalled.
- stall_o=0 in DONE, so the pipeline advances on the edge that leaves DONE.
- Both mem_read_i and mem_write_i set: the write is performed, and data_o returns the word as it was before the write (read-before-write).
- data_o changes only on the completion edge of a read, or on reset.

## Timing
- Request first present in cycle T (IDLE):
  - BUSY occupies cycles T+1 .. T+LATENCY-1.
  - DONE/ack occurs in cycle T+LATENCY.
  - stall_o is high in cycles T .. T+LATENCY-1.
- Memory write and data_o update happen at the edge ending cycle T+LATENCY-1.
- Back-to-back: a new request may appear in the cycle after DONE. Minimum spacing is LATENCY+1 cycles per access. There is no request in the DONE cycle itself.
- Reset (rst_i=0 at an edge):
  - state=IDLE, cnt=0, ack_o=0, err_o=0, data_o=0; stall_o=0 while rst_i=0.
  - Memory array is untouched.
- Reset mid-operation: if rst_i=0 at or before the completion edge, the in-flight access is aborted. No write occurs and no ack is issued.
- Changing addr_i/data_i during BUSY has no effect.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with req=1. Required: ack_o=0, err_o=0, data_o=0, stall_o=0. Release reset: stall_o goes high in the same cycle.
- Store then load, LATENCY=4:
  - Store 0xDEADBEEF to addr 0x10 at T=0: stall_o high in cycles 0–3, ack_o in cycle 4.
  - Load from 0x10 at T=5: ack_o in cycle 9, data_o=0xDEADBEEF, held through idle cycles.
- Errors:
  - Store to addr 0x13 (misaligned): ack_o=1 and err_o=1. A following load from 0x10 still returns 0xDEADBEEF.
  - Load from 4*DEPTH_WORDS: err_o=1, data_o=0.
- Simultaneous read and write to 0x20:
  - Preload mem[8]=0x1111, then issue read+write of 0x2222. Required: data_o=0x1111.
  - A subsequent load of 0x20 returns 0x2222.
- Reset mid-operation:
  - Store 0x5555 to 0x40 and assert rst_i=0 in BUSY cycle T+2. Required: no ack_o.
  - A later load from 0x40 returns the prior contents.
- Randomised sweep: LATENCY=2 and LATENCY=15. Check stall_o duration is exactly LATENCY cycles and ack_o is exactly one cycle wide per access. Compare every read against a scoreboard.
